match_window_counter: RTL and testbench
=======================================

// Module: match_window_counter
// PURPOSE
//  Downstream consumer of the serial pattern detector's one-cycle match flag.
//  Counts match pulses over fixed windows of WINDOW clock cycles.
//  Hands each window's count to the next stage over a valid/ready handshake.
//  Flags results lost because the consumer stalled.
// PARAMETERS
//  WINDOW  16  cycles per counting window (>= 2)
//  CNT_W   8   width of count result; count saturates at 2**CNT_W-1
// PORTS
//  clk        in   1      clock, all logic on rising edge
//  reset      in   1      asynchronous, active-high; clears all state
//  en         in   1      run request, sampled only at window boundaries / in IDLE
//  z_in       in   1      match flag from detector, 1 = match this cycle
//  cnt_out    out  CNT_W  matches counted in last completed window
//  cnt_valid  out  1      cnt_out holds an unconsumed result
//  cnt_ready  in   1      consumer accepts cnt_out when cnt_valid & cnt_ready
//  overrun    out  1      sticky: a window result was dropped
//  win_busy   out  1      1 while a window is in progress (state COUNT)
// BEHAVIOUR
//  Reset values:
//  - state=IDLE; cnt_out=0, cnt_valid=0, overrun=0, win_busy=0.
//  - Internal cycle counter and accumulator = 0.
//  FSM:
//  - IDLE: en=1 -> COUNT next cycle, with cyc=0, acc=0.
//  - IDLE: en=0 -> stay. z_in is ignored in IDLE.
//  - COUNT: every cycle acc <= sat(acc + z_in) and cyc <= cyc+1.
//    - Width of cyc is clog2(WINDOW).
//    - sat() clamps at 2**CNT_W-1; no wrap.
//  - Window end (cyc==WINDOW-1):
//    - res = sat(acc + z_in), so a pulse in the last cycle is counted.
//    - en=1 -> next window starts the following cycle (cyc=0, acc=0). No gap cycle.
//    - en=0 -> IDLE.
//  - en is ignored mid-window; deasserting it never aborts a window.
//  Output register, at window end:
//  - If cnt_valid=0, or (cnt_valid & cnt_ready) this cycle:
//    - cnt_out <= res, cnt_valid <= 1 next cycle.
//    - A simultaneous handshake and new result keeps cnt_valid=1 with the new value.
//  - Else res is dropped, overrun <= 1, and cnt_out is unchanged.
//  Output register, otherwise:
//  - cnt_valid & cnt_ready -> cnt_valid <= 0 next cycle.
//  - cnt_out and cnt_valid are held stable while cnt_valid=1 & cnt_ready=0.
//  Latency:
//  - Result is visible 1 cycle after the last window cycle.
//  - A window spans exactly WINDOW cycles of z_in sampling.
//  Flags:
//  - overrun is cleared only by reset.
//  - win_busy = (state==COUNT), registered with state.
//  Reset mid-operation:
//  - Immediate return to reset values.
//  - In-flight window and any pending result are discarded.
// TESTING
//  1. Assert reset, no clk -> all outputs 0 immediately; win_busy stays 0 with en=0.
//  2. WINDOW=16, en=1, cnt_ready=1, z_in pulses at window cycles 2,6,10
//     -> cnt_out=3, cnt_valid=1 for 1 cycle, 1 cycle after cycle 15.
//  3. Pulse at cycle 15 of window A and cycle 0 of window B
//     -> A reports 1, B reports 1; windows are back-to-back.
//  4. cnt_ready=0 across two windows (counts 2 then 4) -> cnt_out stays 2, overrun=1.
//     Then cnt_ready=1 -> one transfer of 2, cnt_valid=0.
//  5. CNT_W=2, 5 pulses in one window -> cnt_out=3 (saturated), overrun=0.
//  6. Drop en at cycle 5 -> window completes with result and then IDLE, win_busy=0.
//     Separately, assert reset at cycle 7 of a window -> no result, all outputs 0.

Source files
------------

// File: rtl/match_window_counter_if.sv
// Result handoff channel for match_window_counter.
// Producer drives cnt_out/cnt_valid, consumer drives cnt_ready.
interface match_window_counter_if #(
  parameter int CNT_W = 8
);
  logic [CNT_W-1:0] cnt_out;
  logic             cnt_valid;
  logic             cnt_ready;

  modport master (
    output cnt_out,
    output cnt_valid,
    input  cnt_ready
  );

  modport slave (
    input  cnt_out,
    input  cnt_valid,
    output cnt_ready
  );
endinterface

// File: rtl/match_window_counter.sv
// Counts detector match pulses over fixed windows of WINDOW cycles
// and hands each count downstream over a valid/ready channel.
module match_window_counter #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic z_in,
  match_window_counter_if.master out_if,
  output logic overrun,
  output logic win_busy
);

  localparam int CYC_W = $clog2(WINDOW);
  localparam logic [CYC_W-1:0] LAST = CYC_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] MAX = '1;

  typedef enum logic {
    IDLE,
    COUNT
  } state_t;

  state_t state, state_nxt;
  logic [CYC_W-1:0] cyc, cyc_nxt;
  logic [CNT_W-1:0] acc, acc_nxt, res;
  logic win_end, xfer;

  always_comb begin
    res = (acc == MAX) ? acc
                       : acc + CNT_W'(z_in);
    win_end = (state == COUNT) &&
              (cyc == LAST);
    xfer = out_if.cnt_valid &
           out_if.cnt_ready;
    state_nxt = state;
    cyc_nxt = cyc;
    acc_nxt = acc;
    unique case (state)
      IDLE: begin
        if (en) begin
          state_nxt = COUNT;
          cyc_nxt = '0;
          acc_nxt = '0;
        end
      end
      COUNT: begin
        // No gap cycle: a new window restarts straight from the last one
        if (win_end) begin
          state_nxt = en ? COUNT : IDLE;
          cyc_nxt = '0;
          acc_nxt = '0;
        end else begin
          cyc_nxt = cyc + CYC_W'(1);
          acc_nxt = res;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cyc <= '0;
      acc <= '0;
    end else begin
      state <= state_nxt;
      cyc <= cyc_nxt;
      acc <= acc_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_if.cnt_out <= '0;
      out_if.cnt_valid <= 1'b0;
      overrun <= 1'b0;
    end else if (win_end) begin
      // Slot is free if empty or being drained this same cycle
      if (!out_if.cnt_valid || xfer) begin
        out_if.cnt_out <= res;
        out_if.cnt_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (xfer) begin
      out_if.cnt_valid <= 1'b0;
    end
  end

  assign win_busy = (state == COUNT);

endmodule

// File: tb/tb_match_window_counter.sv
// Bench for match_window_counter: table of windows plus hand sequences,
// results checked through a scoreboard queue per DUT instance.
module tb_match_window_counter;

  logic clk = 1'b0;
  logic reset;
  logic en;
  logic z_in;
  logic ready;
  logic ov_b, busy_b;
  logic ov_s, busy_s;

  int checks = 0;
  int errors = 0;
  int q_b[$];
  int q_s[$];
  bit have_prev;
  bit idle;

  match_window_counter_if #(.CNT_W(8)) b_if ();
  match_window_counter_if #(.CNT_W(2)) s_if ();

  assign b_if.cnt_ready = ready;
  assign s_if.cnt_ready = ready;

  match_window_counter #(
    .WINDOW(16),
    .CNT_W (8)
  ) dut_b (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .z_in    (z_in),
    .out_if  (b_if),
    .overrun (ov_b),
    .win_busy(busy_b)
  );

  match_window_counter #(
    .WINDOW(16),
    .CNT_W (2)
  ) dut_s (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .z_in    (z_in),
    .out_if  (s_if),
    .overrun (ov_s),
    .win_busy(busy_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pat;
    int          drop_at;
    logic        en_last;
    int          exp;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat2(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  always @(negedge clk) begin
    int e;
    if (reset === 1'b0 && ready === 1'b1) begin
      if (b_if.cnt_valid === 1'b1) begin
        e = (q_b.size() != 0) ? q_b.pop_front() : -1;
        check("b_result", 32'(b_if.cnt_out), e);
      end
      if (s_if.cnt_valid === 1'b1) begin
        e = (q_s.size() != 0) ? q_s.pop_front() : -1;
        check("s_result", 32'(s_if.cnt_out), e);
      end
    end
  end

  task automatic start();
    en = 1'b1;
    z_in = 1'b1;
    step();
  endtask

  task automatic run_window(input logic [15:0] pat,
                            input int drop_at,
                            input logic en_last,
                            input int exp_b,
                            input int exp_s,
                            input bit push);
    if (push) begin
      q_b.push_back(exp_b);
      q_s.push_back(exp_s);
    end
    for (int k = 0; k < 16; k++) begin
      if (k == 0)
        check("busy_in_window", 32'(busy_b), 1);
      if (k == 1 && have_prev && ready)
        check("valid_one_cycle",
              32'(b_if.cnt_valid), 0);
      en = (k >= drop_at) ? en_last : 1'b1;
      z_in = pat[k];
      step();
    end
    check("b_valid_at_end", 32'(b_if.cnt_valid), 1);
    check("b_out_at_end", 32'(b_if.cnt_out), exp_b);
    check("s_out_at_end", 32'(s_if.cnt_out), exp_s);
    check("busy_after_end", 32'(busy_b), 32'(en_last));
    have_prev = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'h0444, 15, 1'b1, 3};
    vecs[1] = '{16'h8000, 15, 1'b1, 1};
    vecs[2] = '{16'h0001, 15, 1'b1, 1};
    vecs[3] = '{16'h0F01, 15, 1'b1, 5};
    vecs[4] = '{16'hFFFF, 15, 1'b0, 16};
    vecs[5] = '{16'h0202, 5, 1'b0, 2};

    reset = 1'b1;
    en = 1'b0;
    z_in = 1'b0;
    ready = 1'b1;
    have_prev = 1'b0;
    #2;
    check("rst_b_out", 32'(b_if.cnt_out), 0);
    check("rst_b_valid", 32'(b_if.cnt_valid), 0);
    check("rst_b_overrun", 32'(ov_b), 0);
    check("rst_b_busy", 32'(busy_b), 0);
    check("rst_s_valid", 32'(s_if.cnt_valid), 0);
    step();
    reset = 1'b0;
    step();
    step();
    step();
    check("idle_busy", 32'(busy_b), 0);
    check("idle_valid", 32'(b_if.cnt_valid), 0);

    idle = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (idle)
        start();
      run_window(vecs[i].pat, vecs[i].drop_at,
                 vecs[i].en_last, vecs[i].exp,
                 sat2(vecs[i].exp), 1'b1);
      idle = !vecs[i].en_last;
    end
    check("b_no_overrun", 32'(ov_b), 0);
    check("s_sat_no_overrun", 32'(ov_s), 0);

    en = 1'b0;
    z_in = 1'b0;
    step();
    check("drained_b", 32'(b_if.cnt_valid), 0);

    ready = 1'b0;
    start();
    run_window(16'h0011, 15, 1'b1, 2, 2, 1'b1);
    run_window(16'h000F, 15, 1'b0, 2, 2, 1'b0);
    check("stall_b_overrun", 32'(ov_b), 1);
    check("stall_s_overrun", 32'(ov_s), 1);
    step();
    check("stall_hold_out", 32'(b_if.cnt_out), 2);
    check("stall_hold_valid", 32'(b_if.cnt_valid), 1);
    ready = 1'b1;
    step();
    check("stall_drain_b", 32'(b_if.cnt_valid), 0);
    check("stall_drain_s", 32'(s_if.cnt_valid), 0);
    check("stall_overrun_sticky", 32'(ov_b), 1);
    check("q_b_empty", 32'(q_b.size()), 0);
    check("q_s_empty", 32'(q_s.size()), 0);

    start();
    for (int k = 0; k < 7; k++) begin
      en = 1'b1;
      z_in = 1'b1;
      step();
    end
    reset = 1'b1;
    #1;
    check("mid_rst_b_busy", 32'(busy_b), 0);
    check("mid_rst_b_overrun", 32'(ov_b), 0);
    check("mid_rst_s_overrun", 32'(ov_s), 0);
    check("mid_rst_b_out", 32'(b_if.cnt_out), 0);
    check("mid_rst_b_valid", 32'(b_if.cnt_valid), 0);
    en = 1'b0;
    step();
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      z_in = k[0];
      step();
    end
    check("post_rst_busy", 32'(busy_b), 0);
    check("post_rst_valid", 32'(b_if.cnt_valid), 0);
    check("post_rst_q_b", 32'(q_b.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
